// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a single 8N1 UART transmitter.
// One byte per grant; WAIT clocks per bit; per-requester accepted-byte counters.
module uart_tx_arbiter #(
  parameter int unsigned WAIT  = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [7:0]       req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_data,
  output logic             req1_ready,
  output logic             uart_tx,
  output logic             busy,
  output logic             grant_id,
  output logic [CNT_W-1:0] sent0,
  output logic [CNT_W-1:0] sent1
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] WAIT_M1 = 16'(WAIT - 1);

  state_t           state, state_n;
  logic [15:0]      wcnt, wcnt_n;
  logic [2:0]       bcnt, bcnt_n;
  logic [7:0]       shreg, shreg_n;
  logic             tx_n;
  logic             last_grant, last_n;
  logic             gid_n;
  logic [CNT_W-1:0] s0_n, s1_n;
  logic             idle, wait_done, xfer, winner;
  logic [7:0]       wdata;

  assign idle      = (state == IDLE);
  assign busy      = !idle;
  assign wait_done = (wcnt == WAIT_M1);

  // On contention the requester that did not own the last frame wins.
  assign req0_ready = idle && req0_valid && (!req1_valid || last_grant);
  assign req1_ready = idle && req1_valid && (!req0_valid || !last_grant);
  assign xfer       = req0_ready || req1_ready;
  assign winner     = req1_ready;
  assign wdata      = req1_ready ? req1_data : req0_data;

  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    bcnt_n  = bcnt;
    shreg_n = shreg;
    tx_n    = uart_tx;
    last_n  = last_grant;
    gid_n   = grant_id;
    s0_n    = sent0;
    s1_n    = sent1;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (xfer) begin
          shreg_n = wdata;
          last_n  = winner;
          gid_n   = winner;
          if (winner) s1_n = sent1 + CNT_W'(1);
          else        s0_n = sent0 + CNT_W'(1);
          state_n = START;
          tx_n    = 1'b0;
          wcnt_n  = '0;
          bcnt_n  = '0;
        end
      end
      START: begin
        if (wait_done) begin
          wcnt_n  = '0;
          state_n = DATA;
          tx_n    = shreg[0];
        end else begin
          wcnt_n = wcnt + 16'd1;
        end
      end
      DATA: begin
        if (wait_done) begin
          wcnt_n  = '0;
          shreg_n = shreg >> 1;
          // The register drives the line, so the next bit is read one place ahead.
          if (bcnt == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
            bcnt_n  = '0;
          end else begin
            bcnt_n = bcnt + 3'd1;
            tx_n   = shreg[1];
          end
        end else begin
          wcnt_n = wcnt + 16'd1;
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (wait_done) begin
          wcnt_n  = '0;
          state_n = IDLE;
        end else begin
          wcnt_n = wcnt + 16'd1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wcnt       <= '0;
      bcnt       <= '0;
      shreg      <= '0;
      uart_tx    <= 1'b1;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      sent0      <= '0;
      sent1      <= '0;
    end else begin
      state      <= state_n;
      wcnt       <= wcnt_n;
      bcnt       <= bcnt_n;
      shreg      <= shreg_n;
      uart_tx    <= tx_n;
      last_grant <= last_n;
      grant_id   <= gid_n;
      sent0      <= s0_n;
      sent1      <= s1_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: reference model predicts handshakes and
// queues expected frames; an independent line monitor checks each serial frame.
module tb_uart_tx_arbiter;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          req0_valid, req1_valid;
  logic [7:0]    req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          uart_tx, busy, grant_id;
  logic [CW-1:0] sent0, sent1;

  uart_tx_arbiter #(.WAIT(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .uart_tx(uart_tx), .busy(busy), .grant_id(grant_id),
    .sent0(sent0), .sent1(sent1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {logic id; logic [7:0] b;} exp_t;
  exp_t expq[$];

  // Reference model: a frame blocks the arbiter for 10*W cycles after its grant.
  int m_busy = 0;
  int m_last = 1;
  int m_gid  = 0;
  int m_s0   = 0;
  int m_s1   = 0;

  always @(negedge clk) begin
    bit e0, e1;
    if (!rst_n) begin
      chk("rst_tx", uart_tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_sent0", sent0, 0);
      chk("rst_sent1", sent1, 0);
      m_busy = 0; m_last = 1; m_gid = 0; m_s0 = 0; m_s1 = 0;
      expq.delete();
    end else begin
      e0 = (m_busy == 0) && req0_valid && (!req1_valid || m_last == 1);
      e1 = (m_busy == 0) && req1_valid && (!req0_valid || m_last == 0);
      chk("ready0", req0_ready, e0);
      chk("ready1", req1_ready, e1);
      chk("one_ready", req0_ready && req1_ready, 0);
      chk("busy", busy, m_busy != 0);
      chk("sent0", sent0, m_s0 % (1 << CW));
      chk("sent1", sent1, m_s1 % (1 << CW));
      chk("grant_id", grant_id, m_gid);
      if (m_busy > 0) m_busy--;
      else if (e0 || e1) begin
        exp_t e;
        e.id = e1;
        e.b  = e1 ? req1_data : req0_data;
        expq.push_back(e);
        m_busy = 10 * W;
        m_last = e1 ? 1 : 0;
        m_gid  = m_last;
        if (e1) m_s1++; else m_s0++;
      end
    end
  end

  // Line monitor: pops the expected frame when a start bit appears.
  bit        mon_on = 0;
  int        mon_t  = 0;
  exp_t      cur;
  logic [9:0] frame;
  logic [7:0] dec;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_on = 0;
    end else begin
      if (!mon_on && uart_tx == 1'b0) begin
        if (expq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_frame: got start bit want idle line at %0t", $time);
        end else begin
          cur    = expq.pop_front();
          frame  = {1'b1, cur.b, 1'b0};
          mon_on = 1;
          mon_t  = 0;
          chk("frame_gid", grant_id, cur.id);
        end
      end
      if (mon_on) begin
        chk("line", uart_tx, frame[mon_t / W]);
        if (mon_t % W == W / 2 && mon_t / W >= 1 && mon_t / W <= 8)
          dec[mon_t / W - 1] = uart_tx;
        mon_t++;
        if (mon_t == 10 * W) begin
          chk("byte", dec, cur.b);
          mon_on = 0;
        end
      end
    end
  end

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_any(output int who);
    who = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (req0_ready) begin who = 0; return; end
      if (req1_ready) begin who = 1; return; end
    end
    total++; bad++;
    $display("FAIL grant_timeout: got no ready want a grant at %0t", $time);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy && !mon_on && m_busy == 0) begin
        repeat (2) @(negedge clk);
        next_edge();
        return;
      end
    end
    total++; bad++;
    $display("FAIL idle_timeout: got busy want idle at %0t", $time);
  endtask

  task automatic do_reset();
    next_edge();
    rst_n = 1'b0;
    repeat (2) next_edge();
    rst_n = 1'b1;
  endtask

  int    who;
  time   tp, tn;
  logic [7:0] s3 [3];

  initial begin
    rst_n = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("init_tx", uart_tx, 1);
    chk("init_busy", busy, 0);
    chk("init_gid", grant_id, 0);
    chk("init_sent0", sent0, 0);
    chk("init_sent1", sent1, 0);
    repeat (3) next_edge();
    rst_n = 1'b1;

    // Single byte 0x55 from requester 0.
    req0_valid = 1'b1; req0_data = 8'h55;
    wait_any(who);
    chk("s1_who", who, 0);
    next_edge();
    req0_valid = 1'b0;
    wait_idle();
    chk("s1_sent0", sent0, 1);
    chk("s1_gid", grant_id, 0);

    // Continuous contention alternates starting with requester 0.
    do_reset();
    req0_valid = 1'b1; req0_data = 8'hA1;
    req1_valid = 1'b1; req1_data = 8'hB2;
    tp = 0;
    for (int g = 0; g < 4; g++) begin
      wait_any(who);
      tn = $time;
      chk("s2_who", who, g % 2);
      if (g > 0) chk("s2_gap", 32'((tn - tp) / 10), 10 * W + 1);
      tp = tn;
      next_edge();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();
    chk("s2_sent0", sent0, 2);
    chk("s2_sent1", sent1, 2);

    // Lone requester 1, back-to-back.
    do_reset();
    s3[0] = 8'h00; s3[1] = 8'hFF; s3[2] = 8'h3C;
    tp = 0;
    for (int i = 0; i < 3; i++) begin
      req1_valid = 1'b1; req1_data = s3[i];
      wait_any(who);
      tn = $time;
      chk("s3_who", who, 1);
      if (i > 0) chk("s3_gap", 32'((tn - tp) / 10), 10 * W + 1);
      tp = tn;
      next_edge();
    end
    req1_valid = 1'b0;
    wait_idle();
    chk("s3_sent1", sent1, 3);
    chk("s3_sent0", sent0, 0);

    // Counter wrap on requester 0; requester 1 count must stay put.
    do_reset();
    req1_valid = 1'b1; req1_data = 8'h5A;
    wait_any(who);
    next_edge();
    req1_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      req0_valid = 1'b1; req0_data = 8'($urandom);
      wait_any(who);
      chk("s4_who", who, 0);
      next_edge();
      chk("s4_sent0", sent0, (i + 1) % 16);
    end
    req0_valid = 1'b0;
    wait_idle();
    chk("s4_wrap0", sent0, 0);
    chk("s4_sent1", sent1, 1);

    // Reset mid-DATA abandons the frame; requester 0 wins afterwards.
    req1_valid = 1'b1; req1_data = 8'hC3;
    wait_any(who);
    next_edge();
    req1_valid = 1'b0;
    repeat (29) next_edge();
    rst_n = 1'b0;
    #1;
    chk("s5_tx", uart_tx, 1);
    chk("s5_busy", busy, 0);
    chk("s5_sent0", sent0, 0);
    chk("s5_sent1", sent1, 0);
    repeat (3) next_edge();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h11;
    req1_valid = 1'b1; req1_data = 8'h22;
    wait_any(who);
    chk("s5_first", who, 0);
    next_edge();
    wait_any(who);
    chk("s5_second", who, 1);
    next_edge();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();

    // Random traffic, including valids dropping while not granted.
    for (int c = 0; c < 4000; c++) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 2) == 0);
      req0_data  = 8'($urandom);
      req1_data  = 8'($urandom);
      next_edge();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();
    chk("end_queue", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the board's single UART transmit line between two byte producers: requester 0 is the CPU MMIO store path, requester 1 is the self-test/status reporter.
- Round-robin arbitration, one byte per grant.
- Serialises each granted byte as 8N1 with WAIT clocks per bit, matching the bench's UART wait constant.
- Sits between the producers and the board TX pin; also exports per-requester byte counters for bench pass/fail checks.

Parameters:
- WAIT, 8, clocks per UART bit (start, each data bit, stop); legal range 1..65535.
- CNT_W, 16, width of each per-requester sent-byte counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has a byte.
- req0_data  in  8  requester 0 byte.
- req0_ready  out  1  requester 0 byte accepted this cycle.
- req1_valid  in  1  requester 1 has a byte.
- req1_data  in  8  requester 1 byte.
- req1_ready  out  1  requester 1 byte accepted this cycle.
- uart_tx  out  1  serial line, idle high.
- busy  out  1  frame in progress (state != IDLE).
- grant_id  out  1  requester owning the current or last frame.
- sent0  out  CNT_W  bytes accepted from requester 0.
- sent1  out  CNT_W  bytes accepted from requester 1.

Behaviour:
- Reset values (applied asynchronously while rst_n=0):
  - uart_tx=1, busy=0, grant_id=0, sent0=sent1=0.
  - State IDLE, bit counter 0, wait counter 0, shift register 0.
  - last_grant=1, so requester 0 wins the first contention.
- States: IDLE, START, DATA, STOP.
- Handshake in IDLE:
  - ready outputs are combinational and asserted only in IDLE; at most one is high per cycle.
  - Only one valid: that requester gets ready=1.
  - Both valid: the requester != last_grant gets ready=1.
  - Transfer occurs when valid & ready.
  - Valid may drop without penalty while not granted. The data byte is sampled only at the transfer edge.
- On transfer edge:
  - shift register <= data.
  - grant_id <= last_grant <= winner.
  - sent[winner] increments, wrapping 2^CNT_W-1 -> 0.
  - state <= START.
- START: uart_tx=0 for exactly WAIT clocks, then DATA.
- DATA:
  - 8 bits LSB first, each held WAIT clocks.
  - Shift right after each bit; bit counter 0..7.
  - After bit 7 completes, go to STOP.
- STOP: uart_tx=1 for WAIT clocks, then IDLE.
- uart_tx is registered: the start bit appears the cycle after the transfer edge. Frame length is exactly 10*WAIT clocks.
- Back-to-back: the first IDLE cycle after STOP can accept the next byte. Minimum spacing between transfer edges is 10*WAIT+1 clocks, with the line high during the gap cycle.
- Lone requester is granted every frame; round-robin never stalls it.
- No requests: remain in IDLE, uart_tx=1, ready=0.
- busy=1 in START/DATA/STOP, 0 in IDLE.
- Reset mid-frame: line returns high immediately (async), the frame is abandoned, and counters clear. There is no retry of the aborted byte.
- Inputs are assumed synchronous to clk; no X propagation to uart_tx is allowed in any state.

Test Plan:
- After reset, req0_valid=1, data=0x55, WAIT=8 -> req0_ready high 1 cycle. uart_tx sequence: 0 for 8 clocks, then bits 1,0,1,0,1,0,1,0 at 8 clocks each, then 1 for 8 clocks. busy high 80 clocks; sent0=1; grant_id=0.
- req0 and req1 both valid continuously with data 0xA1/0xB2 -> grant order 0,1,0,1. Decoded bytes are A1,B2,A1,B2; sent0=sent1=2 after 4 frames; transfer edges 81 clocks apart.
- Only req1 valid, three bytes 0x00,0xFF,0x3C -> all granted to requester 1 back-to-back with a 1-cycle high gap. Decoded bytes match; sent1=3, sent0=0.
- Preload via 65535 frames (or CNT_W=4 build, 15 frames) then one more from req0 -> sent0 wraps to 0; sent1 unchanged.
- Assert rst_n=0 mid-DATA (clock 30 of a frame) for 3 cycles -> uart_tx=1 and busy=0 the same cycle, counters 0. After release, req1 and req0 both valid -> req0 granted first.
- Both valid in IDLE -> never both ready high in the same cycle (checked every cycle across all scenarios).
